ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter; the opposite direction of the PS/2 keyboard receiver on ps2_clk_io/ps2_data_io.
- Sends one command byte to the keyboard (set LEDs 0xED, reset 0xFF, and so on) with the standard PS/2 host-request sequence.
- Drives both lines open-drain through output-enable signals and checks the device ACK.
- Sits in the top-level next to the keyboard receiver, clocked from clock_48.

---
 rtl/ps2_host_tx.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (clock inhibit, request-to-send, 11-bit frame, ACK check).
// Latency: lines are inhibited the cycle after tx_start; done/error pulse once the device idles or a timer expires.
// Backpressure: tx_start is dropped while busy, including the done/error cycle; nothing is queued.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   tx_data, tx_start     command byte and its one-cycle request
//   ps2_clk_i, ps2_dat_i  asynchronous pad readback of the PS/2 lines
//   ps2_clk_oe, ps2_dat_oe open-drain pull-down enables (1 = drive low)
//   busy, done, error     transfer status and one-cycle completion pulses

// Line conditioner: 2-FF synchroniser followed by a run-length debounce.
// Latency: 2 sync cycles plus FILTER_LEN consecutive differing samples before the level changes.
// Backpressure: none; free-running on every cycle.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the run, so short glitches never get through.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Idle bus level is high, so the synchroniser and level reset to 1 to
    // avoid a phantom falling edge coming out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
endmodule

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 4800,
    parameter int START_TIMEOUT  = 720000,
    parameter int XFER_TIMEOUT   = 96000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);
    // One timer serves all phases; it is sized for the longest wait, so
    // INHIBIT_CYCLES and XFER_TIMEOUT must not exceed START_TIMEOUT.
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX      = '1;
    localparam logic [TW-1:0] INH_PRE   = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] XFER_LST  = TW'(XFER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        WAIT_IDLE,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          clk_prev_q;

    logic          clk_lvl;
    logic          dat_lvl;
    logic          clk_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2_dat_i),
        .level_o (dat_lvl)
    );

    // Single-cycle strobe on the filtered clock going 1 -> 0.
    assign clk_fall  = clk_prev_q & ~clk_lvl;
    assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_inc;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        par_d    = par_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                timer_d  = '0;
                // busy_q is still high in the done cycle, which drops a
                // request arriving alongside the done pulse.
                if (tx_start && !busy_q) begin
                    data_d   = tx_data;
                    par_d    = ~^tx_data;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end

            INHIBIT: begin
                // Start bit goes low on the final inhibit cycle so data is
                // already low when the clock is released.
                if (timer_q == INH_PRE) begin
                    dat_oe_d = 1'b1;
                end
                if (timer_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    state_d  = REQ;
                end
            end

            REQ: begin
                if (clk_fall) begin
                    dat_oe_d = ~data_q[0];
                    bitcnt_d = 4'd1;
                    state_d  = SHIFT;
                end else if (timer_q >= START_LST) begin
                    state_d  = ERR;
                    error_d  = 1'b1;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                end
            end

            SHIFT: begin
                if (clk_fall) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    // bitcnt_q holds the number of edges already seen, so
                    // this edge is bitcnt_q + 1 and drives data bit bitcnt_q.
                    case (bitcnt_q)
                        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                            dat_oe_d = ~data_q[bitcnt_q[2:0]];
                        end
                        4'd8: begin
                            dat_oe_d = ~par_q;
                        end
                        4'd9: begin
                            dat_oe_d = 1'b0;
                        end
                        4'd10: begin
                            if (dat_lvl) begin
                                state_d  = ERR;
                                error_d  = 1'b1;
                                clk_oe_d = 1'b0;
                                dat_oe_d = 1'b0;
                            end else begin
                                state_d = WAIT_IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end else if (timer_q >= XFER_LST) begin
                    state_d  = ERR;
                    error_d  = 1'b1;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                end
            end

            WAIT_IDLE: begin
                if (clk_lvl && dat_lvl) begin
                    // busy stays high through the done cycle; IDLE drops it.
                    done_d   = 1'b1;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = IDLE;
                end else if (timer_q >= XFER_LST) begin
                    state_d  = ERR;
                    error_d  = 1'b1;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                end
            end

            ERR: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        // Every phase measures its own window from its first cycle.
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitcnt_q   <= bitcnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            clk_prev_q <= clk_lvl;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a PS/2 device model on wired-AND lines.
// Latency: device model clocks with a 40-cycle half period and samples data mid-high.
// Backpressure: requests are issued only when the host is idle, except the deliberate mid-transfer one.
module tb_ps2_host_tx;
    localparam int INH  = 600;
    localparam int STO  = 3000;
    localparam int XTO  = 2000;
    localparam int HALF = 40;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;

    logic       dev_clk_low;
    logic       dev_dat_low;
    logic       glitch;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (counts only, sampled 2 time units after each rising edge).
    int cyc       = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int err_cyc   = 0;
    int both_cnt  = 0;
    int busy_bad  = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO),
        .FILTER_LEN     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Open-drain bus: any party pulling low wins.
    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low | glitch);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (done === 1'b1 && error === 1'b1) both_cnt++;
        if ((done === 1'b1 || error === 1'b1) && busy !== 1'b1) busy_bad++;
    end

    // Issue a request and verify the inhibit phase; returns at REQ entry.
    task automatic start_request(input logic [7:0] d);
        int cnt;
        int dcnt;
        int dlast;
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        cnt   = 0;
        dcnt  = 0;
        dlast = 0;
        while (ps2_clk_oe === 1'b1 && cnt < INH + 50) begin
            cnt++;
            if (ps2_dat_oe === 1'b1) begin
                dcnt++;
                dlast = cnt;
            end
            @(negedge clk);
        end
        n_checks++;
        if (cnt != INH) begin
            n_errors++;
            $display("FAIL inhibit_len: got %0d want %0d", cnt, INH);
        end
        n_checks++;
        if (dcnt != 1 || dlast != INH) begin
            n_errors++;
            $display("FAIL inhibit_start_bit: dat_oe cycles %0d last %0d want 1 at %0d", dcnt, dlast, INH);
        end
        n_checks++;
        if (ps2_dat_oe !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL req_entry: dat_oe %b busy %b want 1 1", ps2_dat_oe, busy);
        end
    endtask

    // PS/2 device: generates up to 11 clocks, records start + 10 sampled bits.
    task automatic device_run(input bit ack, input int stall_after, input int glitch_at,
                              input int start_at, input int reset_at,
                              output logic [10:0] frame, output int t1, output bit aborted);
        frame   = '1;
        t1      = 0;
        aborted = 1'b0;
        repeat (60) @(negedge clk);
        frame[0] = ps2_dat_i;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            if (k == 1) t1 = cyc;
            for (int i = 0; i < HALF; i++) begin
                @(negedge clk);
                if (k == reset_at && i == HALF / 2) begin
                    aborted = 1'b1;
                    return;
                end
            end
            dev_clk_low = 1'b0;
            for (int i = 0; i < HALF; i++) begin
                if (i == HALF / 2 && k <= 10) frame[k] = ps2_dat_i;
                if (i == HALF / 2 && k == 10 && ack) dev_dat_low = 1'b1;
                glitch   = (k == glitch_at) && (i >= HALF / 2 + 5) && (i < HALF / 2 + 8);
                tx_start = (k == start_at) && (i == HALF / 2 + 2);
                if (tx_start) tx_data = 8'h55;
                @(negedge clk);
            end
            glitch   = 1'b0;
            tx_start = 1'b0;
            if (k == stall_after) return;
        end
        dev_dat_low = 1'b0;
    endtask

    // Full acknowledged transfer with frame decoding and completion checks.
    task automatic run_good_transfer(input logic [7:0] d, input int glitch_at, input int start_at,
                                     input string name, output logic [10:0] frame);
        int  d0;
        int  e0;
        int  t1;
        bit  ab;
        d0 = done_cnt;
        e0 = err_cnt;
        start_request(d);
        device_run(1'b1, 0, glitch_at, start_at, 0, frame, t1, ab);
        for (int i = 0; i < 300 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (frame[8:1] !== d) begin
            n_errors++;
            $display("FAIL %s_byte: got %02h want %02h", name, frame[8:1], d);
        end
        n_checks++;
        if (($countones(frame[9:1]) % 2) != 1) begin
            n_errors++;
            $display("FAIL %s_parity: data+parity %09b has even ones, want odd", name, frame[9:1]);
        end
        n_checks++;
        if (frame[0] !== 1'b0 || frame[10] !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_framing: start %b stop %b want 0 1", name, frame[0], frame[10]);
        end
        n_checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            n_errors++;
            $display("FAIL %s_done: done pulses %0d error pulses %0d want 1 0", name, done_cnt - d0, err_cnt - e0);
        end
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_release: clk_oe %b dat_oe %b busy %b want 0 0 0", name, ps2_clk_oe, ps2_dat_oe, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, error} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %05b want 00000", {ps2_clk_oe, ps2_dat_oe, busy, done, error});
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, error} !== 5'b0) begin
            n_errors++;
            $display("FAIL idle_outputs: got %05b want 00000", {ps2_clk_oe, ps2_dat_oe, busy, done, error});
        end
    endtask

    task automatic test_send_ed();
        logic [10:0] f;
        run_good_transfer(8'hED, 0, 0, "ed", f);
        n_checks++;
        if (f !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
            n_errors++;
            $display("FAIL ed_frame: got %011b want %011b", f, {1'b1, 1'b1, 8'hED, 1'b0});
        end
    endtask

    task automatic test_parity_bytes();
        logic [7:0]  vals [3];
        logic [10:0] f;
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        vals[2] = 8'h01;
        for (int i = 0; i < 3; i++) begin
            run_good_transfer(vals[i], 0, 0, "parity", f);
        end
    endtask

    task automatic test_random_bytes();
        logic [10:0] f;
        for (int i = 0; i < 3; i++) begin
            run_good_transfer(8'($urandom), 0, 0, "random", f);
        end
    endtask

    task automatic test_no_clock();
        int e0;
        int d0;
        int p;
        e0 = err_cnt;
        d0 = done_cnt;
        start_request(8'($urandom));
        p = cyc;
        for (int i = 0; i < STO + 100 && err_cnt == e0; i++) @(negedge clk);
        n_checks++;
        if (err_cnt - e0 != 1 || err_cyc - p != STO) begin
            n_errors++;
            $display("FAIL start_timeout: pulses %0d after %0d cycles want 1 after %0d", err_cnt - e0, err_cyc - p, STO);
        end
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || done_cnt != d0) begin
            n_errors++;
            $display("FAIL start_timeout_lines: clk_oe %b dat_oe %b done %0d want 0 0 0", ps2_clk_oe, ps2_dat_oe, done_cnt - d0);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            n_errors++;
            $display("FAIL start_timeout_idle: busy %b error %b want 0 0", busy, error);
        end
    endtask

    task automatic test_nack();
        int          e0;
        int          d0;
        int          t1;
        bit          ab;
        logic [10:0] f;
        e0 = err_cnt;
        d0 = done_cnt;
        start_request(8'($urandom));
        device_run(1'b0, 0, 0, 0, 0, f, t1, ab);
        repeat (40) @(negedge clk);
        n_checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            n_errors++;
            $display("FAIL nack: error pulses %0d done pulses %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL nack_release: clk_oe %b dat_oe %b busy %b want 0 0 0", ps2_clk_oe, ps2_dat_oe, busy);
        end
    endtask

    task automatic test_stall();
        int          e0;
        int          d0;
        int          t1;
        bit          ab;
        logic [10:0] f;
        e0 = err_cnt;
        d0 = done_cnt;
        start_request(8'($urandom));
        device_run(1'b1, 5, 0, 0, 0, f, t1, ab);
        for (int i = 0; i < XTO + 100 && err_cnt == e0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            n_errors++;
            $display("FAIL stall: error pulses %0d done pulses %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        n_checks++;
        if (err_cyc - t1 < XTO || err_cyc - t1 > XTO + 20) begin
            n_errors++;
            $display("FAIL stall_time: error %0d cycles after edge 1 want %0d..%0d", err_cyc - t1, XTO, XTO + 20);
        end
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_release: clk_oe %b dat_oe %b busy %b want 0 0 0", ps2_clk_oe, ps2_dat_oe, busy);
        end
    endtask

    task automatic test_mid_start();
        logic [10:0] f;
        int          hits;
        run_good_transfer(8'hA3, 0, 3, "midstart", f);
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) hits++;
            @(negedge clk);
        end
        n_checks++;
        if (hits != 0) begin
            n_errors++;
            $display("FAIL midstart_queued: busy/clk_oe active for %0d cycles want 0", hits);
        end
    endtask

    task automatic test_glitch();
        logic [10:0] f;
        run_good_transfer(8'($urandom), 4, 0, "glitch", f);
    endtask

    task automatic test_reset_mid();
        int          t1;
        bit          ab;
        logic [10:0] f;
        start_request(8'($urandom));
        device_run(1'b1, 0, 0, 0, 5, f, t1, ab);
        n_checks++;
        if (ab !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_pre: aborted %b busy %b want 1 1", ab, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: clk_oe %b dat_oe %b busy %b want 0 0 0", ps2_clk_oe, ps2_dat_oe, busy);
        end
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        run_good_transfer(8'($urandom), 0, 0, "after_reset", f);
    endtask

    task automatic test_invariants();
        n_checks++;
        if (both_cnt != 0) begin
            n_errors++;
            $display("FAIL done_and_error: overlapping cycles %0d want 0", both_cnt);
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_errors++;
            $display("FAIL busy_on_pulse: pulses without busy %0d want 0", busy_bad);
        end
    endtask

    initial begin
        reset       = 1'b1;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        glitch      = 1'b0;
        test_reset();
        test_send_ed();
        test_parity_bytes();
        test_random_bytes();
        test_no_clock();
        test_nack();
        test_stall();
        test_mid_start();
        test_glitch();
        test_reset_mid();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
